// File: rtl/scs8hd_scan_seq.sv
// Scan-chain test sequencer: serially loads a pattern into a falling-edge scan
// chain, fires one capture edge, unloads the response and compares it.
//
// state     | meaning
// IDLE      | waiting for START; SCE/SCD parked low
// SHIFT_IN  | driving the latched pattern MSB-first onto SCD, SCE high
// CAPTURE   | SCE low for one edge so the chain loads its functional D
// SHIFT_OUT | SCE high, zero-fill on SCD, SO sampled into the capture register
// COMPARE   | publish FAIL/ERR_CNT, pulse DONE, return to IDLE
module scs8hd_scan_seq #(
  parameter int CHAIN_LEN = 16,
  parameter int ERR_W     = 8
) (
  input  logic                 CLKN,
  input  logic                 RESETB,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT_IN,
  input  logic [CHAIN_LEN-1:0] EXP_IN,
  input  logic                 CLR_ERR,
  input  logic                 SO,
  output logic                 SCE,
  output logic                 SCD,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 FAIL,
  output logic [ERR_W-1:0]     ERR_CNT,
  output logic [CHAIN_LEN-1:0] CAP_DATA
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    COMPARE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic [CHAIN_LEN-1:0] cap_q, cap_d;
  logic                 sce_q, sce_d;
  logic                 scd_q, scd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 fail_q, fail_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic                 mismatch;

  assign mismatch = (cap_q != exp_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    exp_d   = exp_q;
    cap_d   = cap_q;
    sce_d   = sce_q;
    scd_d   = scd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fail_d  = fail_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        sce_d  = 1'b0;
        scd_d  = 1'b0;
        busy_d = 1'b0;
        if (START) begin
          state_d = SHIFT_IN;
          cnt_d   = '0;
          pat_d   = PAT_IN;
          exp_d   = EXP_IN;
          sce_d   = 1'b1;
          scd_d   = PAT_IN[CHAIN_LEN-1];
          busy_d  = 1'b1;
        end
      end
      SHIFT_IN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = CAPTURE;
          sce_d   = 1'b0;
          scd_d   = 1'b0;
        end else begin
          // pat_q is consumed MSB-first; the next bit to drive sits just below the top
          pat_d = {pat_q[CHAIN_LEN-2:0], 1'b0};
          scd_d = pat_q[CHAIN_LEN-2];
        end
      end
      CAPTURE: begin
        state_d = SHIFT_OUT;
        cnt_d   = '0;
        sce_d   = 1'b1;
        scd_d   = 1'b0;
      end
      SHIFT_OUT: begin
        cap_d = {cap_q[CHAIN_LEN-2:0], SO};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = COMPARE;
          sce_d   = 1'b0;
        end
      end
      COMPARE: begin
        state_d = IDLE;
        cnt_d   = '0;
        fail_d  = mismatch;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        sce_d   = 1'b0;
        scd_d   = 1'b0;
        if (mismatch && (err_q != '1)) begin
          err_d = err_q + ERR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        sce_d   = 1'b0;
        scd_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    if (CLR_ERR) begin
      err_d = '0;
    end
  end

  always_ff @(negedge CLKN or negedge RESETB) begin
    if (!RESETB) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      exp_q   <= '0;
      cap_q   <= '0;
      sce_q   <= 1'b0;
      scd_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      exp_q   <= exp_d;
      cap_q   <= cap_d;
      sce_q   <= sce_d;
      scd_q   <= scd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
    end
  end

  assign SCE      = sce_q;
  assign SCD      = scd_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign FAIL     = fail_q;
  assign ERR_CNT  = err_q;
  assign CAP_DATA = cap_q;

endmodule
